cross_product_arbiter: RTL and testbench

- Shares one pipelined signed cross-product unit among NUM_REQ requesters, e.g. the polygon vertex sorter and the point-inside tester of several geofence channels.
- Each requester supplies a reference point and two points. The block grants access round-robin, computes (p1-ref)x(p2-ref), and returns the result one-hot tagged to the issuing requester.
- Supports lock for back-to-back sequences, such as a 6-edge inside test.

---
 rtl/cross_product_arbiter_if.sv | 28 ++
 rtl/cross_product_arbiter.sv | 151 +++++++++++++++
 tb/tb_cross_product_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/cross_product_arbiter_if.sv
// Requester-side bundle for the shared cross-product unit: per-requester
// operands and request/lock on one side, grant and tagged result on the other.
interface cross_product_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int COORD_W = 10
);
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ-1:0]           lock;
  logic [NUM_REQ*2*COORD_W-1:0] req_ref;
  logic [NUM_REQ*2*COORD_W-1:0] req_p1;
  logic [NUM_REQ*2*COORD_W-1:0] req_p2;
  logic [NUM_REQ-1:0]           gnt;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic signed [2*COORD_W+2:0]  rsp_value;
  logic                         rsp_pos;
  logic                         rsp_zero;
  logic                         busy;

  modport master (
    output req, lock, req_ref, req_p1, req_p2,
    input  gnt, rsp_valid, rsp_value, rsp_pos, rsp_zero, busy
  );

  modport slave (
    input  req, lock, req_ref, req_p1, req_p2,
    output gnt, rsp_valid, rsp_value, rsp_pos, rsp_zero, busy
  );
endinterface

// File: rtl/cross_product_arbiter.sv
// Round-robin arbiter sharing one 3-stage signed cross-product pipeline among
// NUM_REQ requesters; each result returns one-hot tagged to its issuer.
module cross_product_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int COORD_W = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  cross_product_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int SW = 2 * COORD_W;
  localparam int DW = COORD_W + 1;
  localparam int MW = 2 * COORD_W + 2;
  localparam int RW = 2 * COORD_W + 3;

  function automatic logic signed [DW-1:0] coord_diff(
    input logic [COORD_W-1:0] p,
    input logic [COORD_W-1:0] r
  );
    return $signed({1'b0, p}) - $signed({1'b0, r});
  endfunction

  function automatic logic signed [MW-1:0] mul_ext(
    input logic signed [DW-1:0] u,
    input logic signed [DW-1:0] v
  );
    logic signed [MW-1:0] ue;
    logic signed [MW-1:0] ve;
    ue = MW'(u);
    ve = MW'(v);
    return ue * ve;
  endfunction

  function automatic logic signed [RW-1:0] sub_ext(
    input logic signed [MW-1:0] u,
    input logic signed [MW-1:0] v
  );
    logic signed [RW-1:0] ue;
    logic signed [RW-1:0] ve;
    ue = RW'(u);
    ve = RW'(v);
    return ue - ve;
  endfunction

  logic [PW-1:0]             rr_ptr;
  logic [PW-1:0]             gnt_idx;
  logic [PW:0]               scan;
  logic                      gnt_any;
  logic [NUM_REQ-1:0]        gnt;
  logic [SW-1:0]             ref_sel;
  logic [SW-1:0]             p1_sel;
  logic [SW-1:0]             p2_sel;

  logic                      vld_p0;
  logic [NUM_REQ-1:0]        tag_p0;
  logic signed [DW-1:0]      dx1_p0;
  logic signed [DW-1:0]      dy1_p0;
  logic signed [DW-1:0]      dx2_p0;
  logic signed [DW-1:0]      dy2_p0;

  logic                      vld_p1;
  logic [NUM_REQ-1:0]        tag_p1;
  logic signed [MW-1:0]      a_p1;
  logic signed [MW-1:0]      b_p1;
  logic signed [RW-1:0]      diff;

  logic [NUM_REQ-1:0]        rsp_valid_p2;
  logic signed [RW-1:0]      rsp_value_p2;
  logic                      rsp_pos_p2;
  logic                      rsp_zero_p2;

  // Priority scan from rr_ptr, wrapping modulo NUM_REQ; no grant while in reset.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    scan    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      scan = {1'b0, rr_ptr} + (PW+1)'(off);
      if (scan >= (PW+1)'(NUM_REQ)) scan = scan - (PW+1)'(NUM_REQ);
      if (reset && !gnt_any && bus.req[scan[PW-1:0]]) begin
        gnt_any                = 1'b1;
        gnt_idx                = scan[PW-1:0];
        gnt[scan[PW-1:0]]      = 1'b1;
      end
    end
  end

  always_comb begin
    ref_sel = '0;
    p1_sel  = '0;
    p2_sel  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        ref_sel = bus.req_ref[i*SW +: SW];
        p1_sel  = bus.req_p1[i*SW +: SW];
        p2_sel  = bus.req_p2[i*SW +: SW];
      end
    end
  end

  assign diff = sub_ext(a_p1, b_p1);

  // Control state: pointer, stage valids and the registered response.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr       <= '0;
      vld_p0       <= 1'b0;
      vld_p1       <= 1'b0;
      rsp_valid_p2 <= '0;
      rsp_value_p2 <= '0;
      rsp_pos_p2   <= 1'b0;
      rsp_zero_p2  <= 1'b0;
    end else begin
      vld_p0       <= gnt_any;
      vld_p1       <= vld_p0;
      rsp_valid_p2 <= vld_p1 ? tag_p1 : '0;
      if (gnt_any && !bus.lock[gnt_idx])
        rr_ptr <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      if (vld_p1) begin
        rsp_value_p2 <= diff;
        rsp_pos_p2   <= !diff[RW-1] && (diff != '0);
        rsp_zero_p2  <= (diff == '0);
      end
    end
  end

  // Stage 1: operand differences captured at the accepting edge.
  always_ff @(posedge clk) begin
    tag_p0 <= gnt;
    dx1_p0 <= coord_diff(p1_sel[SW-1:COORD_W], ref_sel[SW-1:COORD_W]);
    dy1_p0 <= coord_diff(p1_sel[COORD_W-1:0],  ref_sel[COORD_W-1:0]);
    dx2_p0 <= coord_diff(p2_sel[SW-1:COORD_W], ref_sel[SW-1:COORD_W]);
    dy2_p0 <= coord_diff(p2_sel[COORD_W-1:0],  ref_sel[COORD_W-1:0]);
  end

  // Stage 2: the two partial products.
  always_ff @(posedge clk) begin
    tag_p1 <= tag_p0;
    a_p1   <= mul_ext(dx1_p0, dy2_p0);
    b_p1   <= mul_ext(dx2_p0, dy1_p0);
  end

  assign bus.gnt       = gnt;
  assign bus.rsp_valid = rsp_valid_p2;
  assign bus.rsp_value = rsp_value_p2;
  assign bus.rsp_pos   = rsp_pos_p2;
  assign bus.rsp_zero  = rsp_zero_p2;
  assign bus.busy      = vld_p0 | vld_p1 | (|rsp_valid_p2);
endmodule

// File: tb/tb_cross_product_arbiter.sv
// Directed bench for cross_product_arbiter: hand-computed checks plus a
// queue-based reference model compared against the outputs every cycle.
module tb_cross_product_arbiter;
  localparam int N  = 4;
  localparam int W  = 10;
  localparam int SW = 2 * W;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cross_product_arbiter_if #(.NUM_REQ(N), .COORD_W(W)) bus ();

  cross_product_arbiter #(.NUM_REQ(N), .COORD_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input int rx, input int ry, input int ax,
                         input int ay, input int bx, input int by);
    bus.req_ref[i*SW +: SW] = {W'(rx), W'(ry)};
    bus.req_p1[i*SW +: SW]  = {W'(ax), W'(ay)};
    bus.req_p2[i*SW +: SW]  = {W'(bx), W'(by)};
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic [N-1:0] tag;
    int          val;
  } ent_t;

  ent_t         q[$];
  ent_t         ent;
  int           cyc = 0;
  int           ptr = 0;
  int           win;
  int           m_val  = 0;
  logic         m_pos  = 1'b0;
  logic         m_zero = 1'b0;
  logic         m_ok   = 1'b0;
  logic         exp_busy;
  logic [N-1:0] exp_vld;
  logic [N-1:0] exp_gnt;

  function automatic int cross_of(input int i);
    int rx, ry, ax, ay, bx, by;
    rx = int'(bus.req_ref[i*SW+W +: W]);
    ry = int'(bus.req_ref[i*SW +: W]);
    ax = int'(bus.req_p1[i*SW+W +: W]);
    ay = int'(bus.req_p1[i*SW +: W]);
    bx = int'(bus.req_p2[i*SW+W +: W]);
    by = int'(bus.req_p2[i*SW +: W]);
    return (ax - rx) * (by - ry) - (bx - rx) * (ay - ry);
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (m_ok) begin
        exp_busy = (q.size() != 0);
        exp_vld  = '0;
        if (q.size() != 0 && q[0].due == cyc) begin
          ent     = q.pop_front();
          exp_vld = ent.tag;
          m_val   = ent.val;
          m_pos   = (ent.val > 0);
          m_zero  = (ent.val == 0);
        end
        chk("m_busy",  bus.busy,      exp_busy);
        chk("m_valid", bus.rsp_valid, exp_vld);
        chk("m_value", bus.rsp_value, m_val);
        chk("m_pos",   bus.rsp_pos,   m_pos);
        chk("m_zero",  bus.rsp_zero,  m_zero);
      end
      win     = -1;
      exp_gnt = '0;
      if (reset === 1'b1) begin
        for (int off = 0; off < N; off++) begin
          if (win < 0 && bus.req[(ptr + off) % N]) win = (ptr + off) % N;
        end
      end
      if (win >= 0) exp_gnt[win] = 1'b1;
      if (m_ok) chk("m_gnt", bus.gnt, exp_gnt);
      if (reset !== 1'b1) begin
        q.delete();
        ptr    = 0;
        m_val  = 0;
        m_pos  = 1'b0;
        m_zero = 1'b0;
        m_ok   = 1'b1;
      end else if (win >= 0) begin
        q.push_back('{due: cyc + 3, tag: exp_gnt, val: cross_of(win)});
        if (!bus.lock[win]) ptr = (win + 1) % N;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic single(input string nm, input int i, input int rx, input int ry,
                        input int ax, input int ay, input int bx, input int by,
                        input int ev);
    step();
    set_ops(i, rx, ry, ax, ay, bx, by);
    bus.req    = '0;
    bus.req[i] = 1'b1;
    @(negedge clk);
    chk({nm, "_gnt"}, bus.gnt, 1 << i);
    step();
    bus.req = '0;
    step();
    step();
    @(negedge clk);
    chk({nm, "_valid"}, bus.rsp_valid, 1 << i);
    chk({nm, "_value"}, bus.rsp_value, ev);
    chk({nm, "_pos"},   bus.rsp_pos,   ev > 0);
    chk({nm, "_zero"},  bus.rsp_zero,  ev == 0);
  endtask

  int rr_exp[N] = '{2, 6, 12, 20};

  initial begin
    reset       = 1'b0;
    bus.req     = '0;
    bus.lock    = '0;
    bus.req_ref = '0;
    bus.req_p1  = '0;
    bus.req_p2  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_valid", bus.rsp_valid, 0);
    chk("rst_busy",  bus.busy,      0);
    chk("rst_value", bus.rsp_value, 0);
    chk("rst_pos",   bus.rsp_pos,   0);
    chk("rst_zero",  bus.rsp_zero,  0);
    chk("rst_gnt",   bus.gnt,       0);

    single("unit",   0, 0, 0, 1, 0, 0, 1, 1);
    single("swap",   0, 0, 0, 0, 1, 1, 0, -1);
    single("colin",  0, 0, 0, 2, 2, 4, 4, 0);
    single("xmax",   0, 0, 0, 1023, 0, 0, 1023, 1046529);
    single("xmin",   0, 0, 0, 0, 1023, 1023, 0, -1046529);
    single("xref",   0, 1023, 1023, 0, 1023, 1023, 0, 1046529);
    single("req3",   3, 5, 5, 7, 5, 5, 9, 8);

    // All four requesting, no lock: strict rotation starting from requester 0.
    step();
    for (int i = 0; i < N; i++) set_ops(i, 0, 0, i + 1, 0, 0, i + 2);
    bus.req  = 4'b1111;
    bus.lock = 4'b0000;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("rr_gnt", bus.gnt, 1 << (j % 4));
      if (j >= 3) begin
        chk("rr_valid", bus.rsp_valid, 1 << ((j - 3) % 4));
        chk("rr_value", bus.rsp_value, rr_exp[(j - 3) % 4]);
      end
      step();
    end

    // One accept of requester 0 moves the pointer to 1, then lock requester 1.
    bus.req = 4'b0001;
    step();
    bus.req  = 4'b0111;
    bus.lock = 4'b1010;
    for (int j = 0; j < 6; j++) begin
      if (j == 5) bus.lock = 4'b1000;
      @(negedge clk);
      chk("lock_gnt", bus.gnt, 4'b0010);
      step();
    end
    @(negedge clk);
    chk("unlock_gnt2", bus.gnt, 4'b0100);
    step();
    @(negedge clk);
    chk("unlock_gnt0", bus.gnt, 4'b0001);
    step();
    bus.req  = '0;
    bus.lock = '0;
    repeat (4) step();

    // Three operations in flight, then a one-cycle reset.
    bus.req = 4'b0111;
    step();
    step();
    step();
    bus.req = '0;
    reset   = 1'b0;
    @(negedge clk);
    chk("flight_busy", bus.busy, 1);
    chk("flight_gnt",  bus.gnt,  0);
    step();
    reset = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("post_rst_valid", bus.rsp_valid, 0);
      chk("post_rst_busy",  bus.busy,      0);
      chk("post_rst_value", bus.rsp_value, 0);
      step();
    end
    bus.req = 4'b1001;
    @(negedge clk);
    chk("post_rst_gnt", bus.gnt, 4'b0001);
    step();
    bus.req = '0;
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
